dff_bank_ctrl: RTL and testbench

Arbitrated write controller for a small bank of D flip-flop registers shared by several requesters. Each requester raises a valid/ready write request (address plus data). The controller picks one winner per transaction by round-robin and commits the data into the addressed register. It also provides an asynchronous read port. It sits between requesting datapath blocks and the register bank it owns, sequencing every state change of that bank.

---
 rtl/dff_bank_pkg.sv | 19 +
 rtl/dff_bank_ctrl_rr_arbiter.sv | 36 +++
 rtl/dff_bank_ctrl.sv | 128 ++++++++++++
 tb/tb_dff_bank_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_bank_pkg.sv
// Shared types and default sizing for the dff_bank_ctrl register-bank write controller.
package dff_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // A single-entry bank still needs a one-bit address bus.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dff_bank_ctrl_rr_arbiter.sv
// Combinational round-robin picker: lowest request at or above ptr, else wrap to lowest overall.
module rr_arbiter
    import dff_bank_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx
);

    logic [NREQ-1:0] mask_s;
    logic [NREQ-1:0] masked_s;

    function automatic logic [IW-1:0] lowest_idx(input logic [NREQ-1:0] vec);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = vec[i] ? IW'(i) : idx;
        end
        return idx;
    endfunction

    // Split requests into the upper (>= ptr) half and fall back to the full vector on wrap.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            mask_s[i] = (i >= int'(ptr));
        end
        masked_s  = req & mask_s;
        grant_idx = (masked_s != '0) ? lowest_idx(masked_s) : lowest_idx(req);
        grant     = (req != '0) ? (NREQ'(1'b1) << grant_idx) : '0;
    end

endmodule

// File: rtl/dff_bank_ctrl.sv
// Round-robin arbitrated write controller owning a small DFF register bank with a combinational read port.
// Optional feature: DFF_BANK_CTRL_SYNC_CLR_EN adds req_clr, which turns a commit into a clear-to-zero.
module dff_bank_ctrl
    import dff_bank_pkg::*;
#(
    parameter  int NREQ  = DEF_NREQ,
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = addr_width(DEPTH),
    localparam int IW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
`ifdef DFF_BANK_CTRL_SYNC_CLR_EN
    input  logic [NREQ-1:0]       req_clr,
`endif
    input  logic [AW-1:0]         rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    output logic [IW-1:0]         grant_id,
    output logic                  wr_done,
    output logic                  busy
);

    state_e           state_r;
    logic [IW-1:0]    rr_ptr_r;
    logic [WIDTH-1:0] bank_r [DEPTH];

    logic [NREQ-1:0]  arb_grant_s;
    logic [IW-1:0]    arb_idx_s;
    logic             any_valid_s;
    logic             commit_s;
    logic             addr_ok_s;
    logic [AW-1:0]    wr_addr_s;
    logic [WIDTH-1:0] wr_data_s;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_r),
        .grant     (arb_grant_s),
        .grant_idx (arb_idx_s)
    );

    // Select the granted requester's payload and decide whether this edge commits.
    always_comb begin
        any_valid_s = |req_valid;
        commit_s    = (state_r == ST_GRANT) && req_valid[grant_id];
        wr_addr_s   = req_addr[int'(grant_id)*AW +: AW];
        addr_ok_s   = ({1'b0, wr_addr_s} < (AW+1)'(DEPTH));
`ifdef DFF_BANK_CTRL_SYNC_CLR_EN
        wr_data_s   = req_clr[grant_id] ? '0 : req_data[int'(grant_id)*WIDTH +: WIDTH];
`else
        wr_data_s   = req_data[int'(grant_id)*WIDTH +: WIDTH];
`endif
    end

    // Transaction FSM; IDLE and DONE both arbitrate, so GRANT/DONE alternate under load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            rr_ptr_r  <= '0;
            grant_id  <= '0;
            req_ready <= '0;
            wr_done   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    wr_done <= 1'b0;
                    if (any_valid_s) begin
                        state_r   <= ST_GRANT;
                        grant_id  <= arb_idx_s;
                        req_ready <= arb_grant_s;
                        busy      <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        req_ready <= '0;
                        busy      <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    req_ready <= '0;
                    if (commit_s) begin
                        state_r  <= ST_DONE;
                        rr_ptr_r <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + IW'(1'b1);
                        wr_done  <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        // Requester withdrew before the handshake: abandon without touching the pointer.
                        state_r  <= ST_IDLE;
                        wr_done  <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    req_ready <= '0;
                    wr_done   <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Register bank: only the addressed entry changes on a commit, out-of-range addresses are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_r[i] <= '0;
            end
        end else if (commit_s && addr_ok_s) begin
            bank_r[wr_addr_s] <= wr_data_s;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_r[i] <= bank_r[i];
            end
        end
    end

    // Combinational read with no write bypass; out-of-range reads return zero.
    always_comb begin
        rd_data = ({1'b0, rd_addr} < (AW+1)'(DEPTH)) ? bank_r[rd_addr] : '0;
    end

endmodule

// File: tb/tb_dff_bank_ctrl.sv
// Self-checking bench for dff_bank_ctrl: vector table, directed corner sequences and a randomized run against a transaction model.
module tb_dff_bank_ctrl;
    import dff_bank_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int IW    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [NREQ-1:0]       v_valid;
    logic [NREQ-1:0]       v_clr;
    logic [AW-1:0]         v_addr [NREQ];
    logic [WIDTH-1:0]      v_data [NREQ];
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [AW-1:0]         rd_addr;
    logic [WIDTH-1:0]      rd_data;
    logic [IW-1:0]         grant_id;
    logic                  wr_done;
    logic                  busy;

    int checks   = 0;
    int failures = 0;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]       = v_addr[i];
            req_data[i*WIDTH +: WIDTH] = v_data[i];
        end
    end

    dff_bank_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (v_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
`ifdef DFF_BANK_CTRL_SYNC_CLR_EN
        .req_clr   (v_clr),
`endif
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .grant_id  (grant_id),
        .wr_done   (wr_done),
        .busy      (busy)
    );

    // Transaction-level reference: a pending grant is a one-hot ready, otherwise arbitration happens.
    logic [NREQ-1:0]  m_ready;
    logic             m_done;
    logic             m_busy;
    int               m_gid;
    int               m_ptr;
    logic [WIDTH-1:0] m_bank [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic clr_eff(input int i);
`ifdef DFF_BANK_CTRL_SYNC_CLR_EN
        return v_clr[i];
`else
        return 1'b0;
`endif
    endfunction

    task automatic m_reset();
        m_ready = '0; m_done = 1'b0; m_busy = 1'b0; m_gid = 0; m_ptr = 0;
        for (int a = 0; a < DEPTH; a++) m_bank[a] = '0;
    endtask

    task automatic model_step();
        int w;
        if (m_ready != '0) begin
            w = m_gid;
            m_ready = '0;
            if (v_valid[w]) begin
                if (int'(v_addr[w]) < DEPTH) m_bank[v_addr[w]] = clr_eff(w) ? '0 : v_data[w];
                m_ptr  = (w + 1) % NREQ;
                m_done = 1'b1;
                m_busy = 1'b1;
            end else begin
                m_done = 1'b0;
                m_busy = 1'b0;
            end
        end else begin
            w = rr_pick(v_valid, m_ptr);
            m_done = 1'b0;
            if (w >= 0) begin
                m_ready = NREQ'(1) << w;
                m_gid   = w;
                m_busy  = 1'b1;
            end else begin
                m_busy  = 1'b0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("ready",    32'(req_ready), 32'(m_ready));
        chk("wr_done",  32'(wr_done),   32'(m_done));
        chk("busy",     32'(busy),      32'(m_busy));
        chk("grant_id", 32'(grant_id),  32'(m_gid));
        chk("rd_data",  32'(rd_data),   32'(m_bank[rd_addr]));
    endtask

    task automatic read_check(input string name, input int a, input logic [WIDTH-1:0] exp);
        rd_addr = AW'(a);
        #1;
        chk(name, 32'(rd_data), 32'(exp));
    endtask

    typedef struct {
        int              rq;
        logic [AW-1:0]   addr;
        logic [WIDTH-1:0] data;
        logic [NREQ-1:0] exp_ready;
    } vec_t;

    vec_t             vecs [4];
    logic [WIDTH-1:0] tbl_bank [DEPTH];
    int               grants [$];
    int               rr_exp [5];
    logic [NREQ-1:0]  xfer;

    initial begin
        vecs[0] = '{rq: 2, addr: 2'd1, data: 8'hA5, exp_ready: 4'b0100};
        vecs[1] = '{rq: 0, addr: 2'd0, data: 8'h5A, exp_ready: 4'b0001};
        vecs[2] = '{rq: 1, addr: 2'd2, data: 8'h0F, exp_ready: 4'b0010};
        vecs[3] = '{rq: 3, addr: 2'd3, data: 8'hC3, exp_ready: 4'b1000};
        rr_exp  = '{0, 1, 2, 3, 0};
        for (int a = 0; a < DEPTH; a++) tbl_bank[a] = '0;

        rst = 1'b1; v_valid = '0; v_clr = '0; rd_addr = '0;
        for (int i = 0; i < NREQ; i++) begin v_addr[i] = '0; v_data[i] = '0; end

        // Reset state
        #2 rst = 1'b0;
        m_reset();
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_done",  32'(wr_done),   32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_gid",   32'(grant_id),  32'd0);
        for (int a = 0; a < DEPTH; a++) read_check("rst_bank", a, 8'h00);
        @(posedge clk); #1;
        rst = 1'b1;

        // Table: isolated single writes from IDLE
        for (int t = 0; t < 4; t++) begin
            v_valid[vecs[t].rq] = 1'b1;
            v_addr[vecs[t].rq]  = vecs[t].addr;
            v_data[vecs[t].rq]  = vecs[t].data;
            rd_addr = vecs[t].addr;
            tick();
            chk("tbl_ready", 32'(req_ready), 32'(vecs[t].exp_ready));
            chk("tbl_nobypass", 32'(rd_data), 32'(tbl_bank[vecs[t].addr]));
            tick();
            chk("tbl_done", 32'(wr_done), 32'd1);
            v_valid = '0;
            tbl_bank[vecs[t].addr] = vecs[t].data;
            tick();
            chk("tbl_idle", 32'(busy), 32'd0);
            for (int a = 0; a < DEPTH; a++) read_check("tbl_bank", a, tbl_bank[a]);
        end

        // Continuous load from all four: grants 0,1,2,3,0 and wr_done every other cycle
        for (int i = 0; i < NREQ; i++) begin
            v_valid[i] = 1'b1; v_addr[i] = AW'(i); v_data[i] = 8'h10 + 8'(i);
        end
        for (int c = 1; c <= 10; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) grants.push_back(i);
            chk("rr_onehot", 32'($countones(req_ready)), (c % 2 == 1) ? 32'd1 : 32'd0);
            chk("rr_done", 32'(wr_done), (c % 2 == 0) ? 32'd1 : 32'd0);
        end
        v_valid = '0;
        tick();
        chk("rr_count", 32'(grants.size()), 32'd5);
        for (int k = 0; k < 5 && k < grants.size(); k++) chk("rr_order", 32'(grants[k]), 32'(rr_exp[k]));

        // Requester 1 withdraws during its grant: no write, pointer stays at 1
        v_valid[1] = 1'b1; v_addr[1] = 2'd0; v_data[1] = 8'hEE;
        tick();
        chk("drop_ready", 32'(req_ready), 32'b0010);
        v_valid[1] = 1'b0;
        tick();
        chk("drop_done", 32'(wr_done), 32'd0);
        chk("drop_busy", 32'(busy), 32'd0);
        read_check("drop_bank", 0, 8'h10);
        v_valid = 4'b0011; v_addr[0] = 2'd0; v_data[0] = 8'h44;
        tick();
        chk("drop_ptr", 32'(req_ready), 32'b0010);
        tick();
        v_valid = '0;
        tick();
        read_check("drop_commit", 0, 8'hEE);

        // Back-to-back writes to one address from requesters 0 then 1
        v_valid = 4'b0011;
        v_addr[0] = 2'd2; v_data[0] = 8'h11;
        v_addr[1] = 2'd2; v_data[1] = 8'h22;
        rd_addr = 2'd2;
        tick();
        chk("b2b_g0", 32'(req_ready), 32'b0001);
        tick();
        chk("b2b_done0", 32'(wr_done), 32'd1);
        v_valid[0] = 1'b0;
        tick();
        chk("b2b_g1", 32'(req_ready), 32'b0010);
        chk("b2b_gap", 32'(wr_done), 32'd0);
        tick();
        chk("b2b_done1", 32'(wr_done), 32'd1);
        v_valid = '0;
        tick();
        read_check("b2b_final", 2, 8'h22);

        // Reset asserted in the middle of a GRANT cycle
        v_valid[3] = 1'b1; v_addr[3] = 2'd1; v_data[3] = 8'h3C;
        tick();
        chk("rstg_ready", 32'(req_ready), 32'b1000);
        #2 rst = 1'b0;
        m_reset();
        #1;
        chk("rstg_busy",  32'(busy),      32'd0);
        chk("rstg_ready0", 32'(req_ready), 32'd0);
        chk("rstg_done",  32'(wr_done),   32'd0);
        for (int a = 0; a < DEPTH; a++) read_check("rstg_bank", a, 8'h00);
        v_valid = '0;
        @(posedge clk); #1;
        chk("rstg_nodone", 32'(wr_done), 32'd0);
        rst = 1'b1;

`ifdef DFF_BANK_CTRL_SYNC_CLR_EN
        // Clear qualifier overrides the data
        v_valid[0] = 1'b1; v_addr[0] = 2'd3; v_data[0] = 8'hFF; v_clr[0] = 1'b0;
        tick(); tick();
        v_valid = '0;
        tick();
        read_check("clr_pre", 3, 8'hFF);
        v_valid[0] = 1'b1; v_data[0] = 8'h77; v_clr[0] = 1'b1;
        tick(); tick();
        chk("clr_done", 32'(wr_done), 32'd1);
        v_valid = '0; v_clr = '0;
        tick();
        read_check("clr_post", 3, 8'h00);
`endif

        // Randomized traffic, mostly protocol-abiding with occasional withdrawals
        for (int c = 0; c < 400; c++) begin
            xfer = m_ready & v_valid;
            rd_addr = AW'($urandom_range(0, DEPTH - 1));
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (xfer[i] || !v_valid[i]) begin
                    v_valid[i] = ($urandom_range(0, 1) == 1);
                    v_addr[i]  = AW'($urandom);
                    v_data[i]  = WIDTH'($urandom);
                    v_clr[i]   = ($urandom_range(0, 3) == 0);
                end else if ($urandom_range(0, 15) == 0) begin
                    v_valid[i] = 1'b0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
